// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared widths and defaults for the PWM control and generator stages
package pwm_pkg;

    localparam int PWM_W = 8;

    localparam logic [PWM_W-1:0] DEF_STEP            = 8'd16;
    localparam int               DEF_DEBOUNCE_CYCLES = 16;
    localparam int               DEF_RAMP_FRAMES     = 1;

    function automatic logic [PWM_W-1:0] clamp_to(input logic [PWM_W-1:0] v,
                                                  input logic [PWM_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/pwm_duty_ctrl_sw_debounce.sv
// rtl/pwm_duty_ctrl_sw_debounce.sv - button synchroniser, debouncer and rising-edge press
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic level,
    output logic press
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          accept;

    // A new level is taken on the DEBOUNCE_CYCLES-th consecutive differing sample
    assign accept = (sync2 != level) && (cnt == CNT_LAST);
    assign press  = accept && sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// rtl/pwm_duty_ctrl.sv - frame-aligned period/duty control with press stepping and soft slew
module pwm_duty_ctrl
    import pwm_pkg::*;
#(
    parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [PWM_W-1:0] STEP            = DEF_STEP,
    parameter int               RAMP_FRAMES     = DEF_RAMP_FRAMES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             duty_sw,
    input  logic [PWM_W-1:0] period_in,
    output logic [PWM_W-1:0] period,
    output logic [PWM_W-1:0] pulse_width,
    output logic [PWM_W-1:0] target,
    output logic             busy,
    output logic             step_evt
);

    localparam int             RDW       = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
    localparam logic [RDW-1:0] RDIV_LAST = RDW'(RAMP_FRAMES - 1);

    logic             rst_meta;
    logic             rst_i;
    logic             press;
    logic             btn_level_unused;
    logic [PWM_W-1:0] fcnt;
    logic [RDW-1:0]   rdiv;
    logic             frame_end;
    logic             ramp_tick;
    logic [PWM_W:0]   step_sum;
    logic [PWM_W-1:0] t_step;
    logic [PWM_W-1:0] t_next;
    logic [PWM_W-1:0] pw_slew;
    logic [PWM_W-1:0] pw_next;

    // Asynchronous assert, release two clocks after rst_n rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta <= 1'b0;
            rst_i    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_i    <= rst_meta;
        end
    end

    sw_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_i),
        .sw    (duty_sw),
        .level (btn_level_unused),
        .press (press)
    );

    always_comb begin
        frame_end = (fcnt == period);
        ramp_tick = frame_end && (rdiv == RDIV_LAST);
        step_sum  = {1'b0, target} + {1'b0, STEP};

        // Step wraps against the period in force; the frame-end clamp follows it
        t_step = target;
        if (press) begin
            t_step = (step_sum > {1'b0, period}) ? '0 : step_sum[PWM_W-1:0];
        end
        t_next = frame_end ? clamp_to(t_step, period_in) : t_step;

        // Slew chases the pre-update target; a shrinking period overrides it
        pw_slew = pulse_width;
        if (ramp_tick) begin
            if (pulse_width < target) begin
                pw_slew = pulse_width + 8'd1;
            end else if (pulse_width > target) begin
                pw_slew = pulse_width - 8'd1;
            end
        end
        pw_next = frame_end ? clamp_to(pw_slew, period_in) : pw_slew;
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            fcnt        <= '0;
            rdiv        <= '0;
            period      <= '1;
            pulse_width <= '0;
            target      <= '0;
            busy        <= 1'b0;
            step_evt    <= 1'b0;
        end else begin
            fcnt        <= frame_end ? '0 : fcnt + 8'd1;
            period      <= frame_end ? period_in : period;
            if (frame_end) begin
                rdiv <= ramp_tick ? '0 : rdiv + RDW'(1);
            end
            target      <= t_next;
            pulse_width <= pw_next;
            busy        <= (pw_next != t_next);
            step_evt    <= press;
        end
    end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// tb/tb_pwm_duty_ctrl.sv - randomized and directed bench against a reference model
module tb_pwm_duty_ctrl;

    localparam int DC   = 16;
    localparam int STEP = 16;
    localparam int RF   = 1;

    logic       clk;
    logic       rst_n;
    logic       duty_sw;
    logic [7:0] period_in;
    logic [7:0] period;
    logic [7:0] pulse_width;
    logic [7:0] target;
    logic       busy;
    logic       step_evt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int evt_total = 0;
    int evt_cyc = 0;

    // reference model state
    int m_rs = 0;
    int m_s1 = 0, m_s2 = 0, m_lvl = 0, m_run = 0;
    int m_fcnt = 0, m_period = 255, m_pw = 0, m_tgt = 0, m_frames = 0;
    int m_busy = 0, m_evt = 0;

    pwm_duty_ctrl #(
        .DEBOUNCE_CYCLES(DC),
        .STEP           (8'(STEP)),
        .RAMP_FRAMES    (RF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .duty_sw     (duty_sw),
        .period_in   (period_in),
        .period      (period),
        .pulse_width (pulse_width),
        .target      (target),
        .busy        (busy),
        .step_evt    (step_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0;
        m_fcnt = 0; m_period = 255; m_pw = 0; m_tgt = 0; m_frames = 0;
        m_busy = 0; m_evt = 0;
    endtask

    task automatic model_step();
        int smp, nt, npw, pin;
        bit pressed, fe;
        pin = int'(period_in);
        if (!rst_n) begin
            model_clear();
            m_rs = 0;
        end else if (m_rs < 2) begin
            m_rs++;
        end else begin
            smp  = m_s2;
            m_s2 = m_s1;
            m_s1 = int'(duty_sw);
            pressed = 0;
            if (smp == m_lvl) m_run = 0;
            else begin
                m_run++;
                if (m_run == DC) begin
                    m_lvl = smp;
                    m_run = 0;
                    pressed = (smp == 1);
                end
            end
            fe = (m_fcnt == m_period);
            nt = m_tgt;
            if (pressed) nt = (m_tgt + STEP > m_period) ? 0 : m_tgt + STEP;
            if (fe && nt > pin) nt = pin;
            npw = m_pw;
            if (fe) begin
                m_frames++;
                if (m_frames == RF) begin
                    m_frames = 0;
                    if (m_pw < m_tgt) npw = m_pw + 1;
                    else if (m_pw > m_tgt) npw = m_pw - 1;
                end
                if (npw > pin) npw = pin;
                m_period = pin;
                m_fcnt = 0;
            end else begin
                m_fcnt++;
            end
            m_tgt  = nt;
            m_pw   = npw;
            m_evt  = pressed;
            m_busy = (npw != nt);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            check_eq("rst_period", int'(period), 255);
            check_eq("rst_pulse_width", int'(pulse_width), 0);
            check_eq("rst_target", int'(target), 0);
            check_eq("rst_busy", int'(busy), 0);
            check_eq("rst_step_evt", int'(step_evt), 0);
        end else begin
            check_eq("period", int'(period), m_period);
            check_eq("pulse_width", int'(pulse_width), m_pw);
            check_eq("target", int'(target), m_tgt);
            check_eq("busy", int'(busy), m_busy);
            check_eq("step_evt", int'(step_evt), m_evt);
            if (step_evt) begin
                evt_total++;
                evt_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic press_once();
        duty_sw = 1'b1;
        tick(30);
        duty_sw = 1'b0;
        tick(30);
    endtask

    task automatic wait_pw(input int want, input int budget, input string tag);
        int n = 0;
        while (m_pw != want && n < budget) begin
            tick(1);
            n++;
        end
        check_eq(tag, int'(n < budget), 1);
    endtask

    task automatic wait_period(input int want, input int budget, input string tag);
        int n = 0;
        while (m_period != want && n < budget) begin
            tick(1);
            n++;
        end
        check_eq(tag, int'(n < budget), 1);
    endtask

    initial begin
        int base, rise, cap, n;
        rst_n     = 1'b0;
        duty_sw   = 1'b0;
        period_in = 8'd99;
        tick(3);
        rst_n = 1'b1;
        tick(4);

        // debounce: bouncy toggles then a clean hold
        base = evt_total;
        for (int i = 0; i < 6; i++) begin
            duty_sw = ~duty_sw;
            tick(5);
        end
        duty_sw = 1'b1;
        rise = cyc;
        tick(40);
        duty_sw = 1'b0;
        tick(40);
        check_eq("db_events", evt_total - base, 1);
        check_eq("db_target", int'(target), 16);
        check_eq("db_latency_in_range", int'((evt_cyc - rise >= 18) && (evt_cyc - rise <= 20)), 1);

        // reset mid-ramp
        wait_pw(8, 3000, "mid_ramp_timeout");
        rst_n = 1'b0;
        #2;
        check_eq("async_rst_pw", int'(pulse_width), 0);
        check_eq("async_rst_target", int'(target), 0);
        check_eq("async_rst_period", int'(period), 255);
        check_eq("async_rst_busy", int'(busy), 0);
        tick(3);
        rst_n = 1'b1;
        tick(4);

        // slew 0 -> 16 at period 99
        press_once();
        check_eq("slew_target", int'(target), 16);
        wait_pw(16, 3000, "slew_timeout");
        check_eq("slew_pw", int'(pulse_width), 16);
        check_eq("slew_busy", int'(busy), 0);

        // wrap at period 40
        do_reset();
        period_in = 8'd40;
        wait_period(40, 600, "wrap_period_timeout");
        press_once();
        check_eq("wrap_t1", int'(target), 16);
        press_once();
        check_eq("wrap_t2", int'(target), 32);
        press_once();
        check_eq("wrap_t3", int'(target), 0);
        wait_pw(0, 5000, "wrap_down_timeout");
        check_eq("wrap_pw", int'(pulse_width), 0);

        // clamp: 80/80 at period 200, then period drops to 50
        do_reset();
        period_in = 8'd200;
        wait_period(200, 600, "clamp_period_timeout");
        repeat (5) press_once();
        check_eq("clamp_target80", int'(target), 80);
        wait_pw(80, 20000, "clamp_ramp_timeout");
        check_eq("clamp_pw80", int'(pulse_width), 80);
        period_in = 8'd50;
        wait_period(50, 400, "clamp_drop_timeout");
        check_eq("clamp_period", int'(period), 50);
        check_eq("clamp_target", int'(target), 50);
        check_eq("clamp_pw", int'(pulse_width), 50);

        // collision: press lands on the frame_end cycle
        do_reset();
        period_in = 8'd40;
        wait_period(40, 600, "coll_period_timeout");
        press_once();
        press_once();
        check_eq("coll_target32", int'(target), 32);
        wait_pw(10, 2000, "coll_ramp_timeout");
        n = 0;
        while (m_fcnt != 23 && n < 100) begin
            tick(1);
            n++;
        end
        check_eq("coll_align_timeout", int'(n < 100), 1);
        cap = m_pw;
        duty_sw   = 1'b1;
        period_in = 8'd20;
        tick(18);
        check_eq("coll_step_evt", int'(step_evt), 1);
        check_eq("coll_target", int'(target), 0);
        check_eq("coll_period", int'(period), 20);
        check_eq("coll_pw", int'(pulse_width), cap + 1);
        duty_sw = 1'b0;
        tick(40);

        // randomized presses, bounces and period changes
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) period_in = 8'($urandom_range(0, 120));
            repeat ($urandom_range(0, 4)) begin
                duty_sw = 1'b1;
                tick(int'($urandom_range(1, 8)));
                duty_sw = 1'b0;
                tick(int'($urandom_range(1, 8)));
            end
            duty_sw = 1'b1;
            tick(int'($urandom_range(8, 40)));
            duty_sw = 1'b0;
            tick(int'($urandom_range(10, 60)));
        end
        tick(50);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
